// File: rtl/ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, T-states,
// the control-word layout and the per-opcode instruction length.
package ctrl_pkg;

  // 4-bit opcodes found in ir[7:4]; 9..D are unused and run as NOP.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-states: T0/T1 fetch, T2..T4 execute.
  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  // One field per datapath strobe.
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out;
    logic ram_load;
    logic ir_load;
    logic ir_out;
    logic a_load;
    logic a_out;
    logic b_load;
    logic alu_out;
    logic alu_sub;
    logic flags_load;
    logic out_load;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '0;

  // Last execute T-state of an opcode; the step counter wraps after it.
  function automatic tstate_t last_step_of(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: return T3;
      OP_ADD, OP_SUB: return T4;
      default:        return T2;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// T-state counter and halt flag of the control sequencer.
// Wraps to T0 after the last execute step of the current instruction and
// freezes (step and halt flag) once a HLT completes, until rst.
module ctrl_step_counter
  import ctrl_pkg::*;
#(
  parameter int LAST_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_done,
  input  logic       halt_req,
  output logic [2:0] step,
  output logic       halted
);

  localparam logic [2:0] STEP_MAX = 3'(LAST_STEP);

  tstate_t state_q, state_d;
  logic    halted_q, halted_d;

  // Next-state: halt has priority, then end-of-instruction wrap, else advance.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (halt_req) begin
        halted_d = 1'b1;
      end else if (instr_done || (state_q >= STEP_MAX)) begin
        state_d = T0;
      end else begin
        state_d = tstate_t'(state_q + 3'd1);
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign step   = state_q;
  assign halted = halted_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit of the 8-bit CPU: decodes the current T-state,
// opcode and flags into datapath load / bus-drive strobes.
// Optional feature macro: CTRL_COND_JUMP_EN enables JC/JZ; when undefined
// opcodes 7 and 8 run as NOP and zf/cf are ignored.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int LAST_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic       zf,
  input  logic       cf,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_load,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] step
);

  logic [3:0] opcode;
  tstate_t    t;
  ctrl_word_t cw, cw_gated;
  logic       instr_done;
  logic       halt_req;

  assign opcode = ir[7:4];
  assign t      = tstate_t'(step);

  // The operand only reaches the bus through the IR itself, never through here.
`ifdef CTRL_COND_JUMP_EN
  logic unused_operand;
  assign unused_operand = ^ir[3:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{ir[3:0], zf, cf};
`endif

  ctrl_step_counter #(
    .LAST_STEP(LAST_STEP)
  ) u_step_counter (
    .clk       (clk),
    .rst       (rst),
    .instr_done(instr_done),
    .halt_req  (halt_req),
    .step      (step),
    .halted    (halted)
  );

  // Decode ROM: fetch strobes for T0/T1, opcode-specific strobes from T2.
  always_comb begin
    cw         = CW_NONE;
    instr_done = 1'b0;
    halt_req   = 1'b0;
    case (t)
      T0: begin
        cw.pc_out   = 1'b1;
        cw.mar_load = 1'b1;
      end
      T1: begin
        cw.ram_out = 1'b1;
        cw.ir_load = 1'b1;
        cw.pc_inc  = 1'b1;
      end
      default: begin
        instr_done = (t == last_step_of(opcode));
        case (opcode)
          OP_LDA: begin
            if (t == T2) begin cw.ir_out  = 1'b1; cw.mar_load = 1'b1; end
            if (t == T3) begin cw.ram_out = 1'b1; cw.a_load   = 1'b1; end
          end
          OP_ADD, OP_SUB: begin
            if (t == T2) begin cw.ir_out  = 1'b1; cw.mar_load = 1'b1; end
            if (t == T3) begin cw.ram_out = 1'b1; cw.b_load   = 1'b1; end
            if (t == T4) begin
              cw.alu_out    = 1'b1;
              cw.a_load     = 1'b1;
              cw.flags_load = 1'b1;
              cw.alu_sub    = (opcode == OP_SUB);
            end
          end
          OP_STA: begin
            if (t == T2) begin cw.ir_out = 1'b1; cw.mar_load = 1'b1; end
            if (t == T3) begin cw.a_out  = 1'b1; cw.ram_load = 1'b1; end
          end
          OP_LDI: begin
            if (t == T2) begin cw.ir_out = 1'b1; cw.a_load = 1'b1; end
          end
          OP_JMP: begin
            if (t == T2) begin cw.ir_out = 1'b1; cw.pc_load = 1'b1; end
          end
`ifdef CTRL_COND_JUMP_EN
          OP_JC: begin
            if (t == T2 && cf) begin cw.ir_out = 1'b1; cw.pc_load = 1'b1; end
          end
          OP_JZ: begin
            if (t == T2 && zf) begin cw.ir_out = 1'b1; cw.pc_load = 1'b1; end
          end
`endif
          OP_OUT: begin
            if (t == T2) begin cw.a_out = 1'b1; cw.out_load = 1'b1; end
          end
          OP_HLT: begin
            halt_req = (t == T2);
          end
          default: ;
        endcase
      end
    endcase
  end

  // Nothing may strobe during reset or while halted.
  assign cw_gated = (rst || halted) ? CW_NONE : cw;

  assign pc_out     = cw_gated.pc_out;
  assign pc_inc     = cw_gated.pc_inc;
  assign pc_load    = cw_gated.pc_load;
  assign mar_load   = cw_gated.mar_load;
  assign ram_out    = cw_gated.ram_out;
  assign ram_load   = cw_gated.ram_load;
  assign ir_load    = cw_gated.ir_load;
  assign ir_out     = cw_gated.ir_out;
  assign a_load     = cw_gated.a_load;
  assign a_out      = cw_gated.a_out;
  assign b_load     = cw_gated.b_load;
  assign alu_out    = cw_gated.alu_out;
  assign alu_sub    = cw_gated.alu_sub;
  assign flags_load = cw_gated.flags_load;
  assign out_load   = cw_gated.out_load;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: hand-written per-cycle vector
// table, multi-cycle corner sequences (halt, reset mid-instruction), and a
// randomized run against a per-opcode micro-program reference model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir;
  logic       zf, cf;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load;
  logic       ir_load, ir_out, a_load, a_out, b_load;
  logic       alu_out, alu_sub, flags_load, out_load;
  logic       halted;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst), .ir(ir), .zf(zf), .cf(cf),
    .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load),
    .mar_load(mar_load), .ram_out(ram_out), .ram_load(ram_load),
    .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load), .a_out(a_out),
    .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub),
    .flags_load(flags_load), .out_load(out_load),
    .halted(halted), .step(step)
  );

  // Strobe bit positions in the packed observation vector.
  localparam logic [14:0] PC_OUT     = 15'h4000;
  localparam logic [14:0] PC_INC     = 15'h2000;
  localparam logic [14:0] PC_LOAD    = 15'h1000;
  localparam logic [14:0] MAR_LOAD   = 15'h0800;
  localparam logic [14:0] RAM_OUT    = 15'h0400;
  localparam logic [14:0] RAM_LOAD   = 15'h0200;
  localparam logic [14:0] IR_LOAD    = 15'h0100;
  localparam logic [14:0] IR_OUT     = 15'h0080;
  localparam logic [14:0] A_LOAD     = 15'h0040;
  localparam logic [14:0] A_OUT      = 15'h0020;
  localparam logic [14:0] B_LOAD     = 15'h0010;
  localparam logic [14:0] ALU_OUT    = 15'h0008;
  localparam logic [14:0] ALU_SUB    = 15'h0004;
  localparam logic [14:0] FLAGS_LOAD = 15'h0002;
  localparam logic [14:0] OUT_LOAD   = 15'h0001;
  localparam logic [14:0] BUS_MASK   = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;
  localparam logic [14:0] FETCH0     = PC_OUT | MAR_LOAD;
  localparam logic [14:0] FETCH1     = RAM_OUT | IR_LOAD | PC_INC;
`ifdef CTRL_COND_JUMP_EN
  localparam logic [14:0] JUMP_TAKEN = IR_OUT | PC_LOAD;
`else
  localparam logic [14:0] JUMP_TAKEN = 15'h0000;
`endif

  logic [14:0] strobes;
  assign strobes = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load,
                    ir_load, ir_out, a_load, a_out, b_load,
                    alu_out, alu_sub, flags_load, out_load};

  int n_pass  = 0;
  int n_total = 0;
  int n_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Sample one cycle at the negedge, then move to just after the next posedge.
  task automatic cycle(input string name, input logic [2:0] exp_step,
                       input logic exp_halted, input logic [14:0] exp_strobes);
    @(negedge clk);
    check({name, " strobes"}, 32'(strobes), 32'(exp_strobes));
    check({name, " step"}, 32'(step), 32'(exp_step));
    check({name, " halted"}, 32'(halted), 32'(exp_halted));
    check({name, " bus exclusive"}, 32'($countones(strobes & BUS_MASK) <= 1), 32'd1);
    check({name, " step range"}, 32'(step <= 3'd4), 32'd1);
    n_cycles++;
    @(posedge clk);
    #1;
  endtask

  // Table of per-cycle vectors: inputs applied, outputs expected.
  typedef struct {
    logic [7:0]  ir;
    logic        zf;
    logic        cf;
    logic [2:0]  step;
    logic [14:0] strobes;
  } vec_t;

  vec_t vecs[$];

  // Push one instruction's worth of vectors: fetch plus execute words w2..w4.
  task automatic add_instr(input logic [7:0] i, input logic z, input logic c, input int n,
                           input logic [14:0] w2, input logic [14:0] w3, input logic [14:0] w4);
    logic [14:0] words [5];
    words = '{FETCH0, FETCH1, w2, w3, w4};
    for (int k = 0; k < n; k++)
      vecs.push_back('{ir: i, zf: z, cf: c, step: 3'(k), strobes: words[k]});
  endtask

  // Reference model: execute micro-program per opcode and instruction length.
  logic [14:0] uprog [16][3];
  int          ilen  [16];

  task automatic init_model();
    for (int op = 0; op < 16; op++) begin
      uprog[op] = '{15'h0, 15'h0, 15'h0};
      ilen[op]  = 3;
    end
    uprog[1]  = '{IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, 15'h0};                    ilen[1] = 4;
    uprog[2]  = '{IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD | FLAGS_LOAD}; ilen[2] = 5;
    uprog[3]  = '{IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
                  ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB};                        ilen[3] = 5;
    uprog[4]  = '{IR_OUT | MAR_LOAD, A_OUT | RAM_LOAD, 15'h0};                     ilen[4] = 4;
    uprog[5]  = '{IR_OUT | A_LOAD, 15'h0, 15'h0};
    uprog[6]  = '{IR_OUT | PC_LOAD, 15'h0, 15'h0};
    uprog[7]  = '{JUMP_TAKEN, 15'h0, 15'h0};
    uprog[8]  = '{JUMP_TAKEN, 15'h0, 15'h0};
    uprog[14] = '{A_OUT | OUT_LOAD, 15'h0, 15'h0};
  endtask

  function automatic logic [14:0] ref_strobes(input logic [7:0] i, input logic z,
                                              input logic c, input int t);
    int op;
    op = int'(i[7:4]);
    if (t == 0) return FETCH0;
    if (t == 1) return FETCH1;
    if (op == 7 && !c) return 15'h0;
    if (op == 8 && !z) return 15'h0;
    return uprog[op][t - 2];
  endfunction

  // Run one instruction with ir garbage during fetch and the real ir from T2.
  task automatic run_ref(input logic [7:0] i, input logic z, input logic c);
    int op;
    op = int'(i[7:4]);
    for (int t = 0; t < ilen[op]; t++) begin
      ir = (t < 2) ? 8'($urandom) : i;
      zf = (t < 2) ? 1'($urandom) : z;
      cf = (t < 2) ? 1'($urandom) : c;
      cycle("random", 3'(t), 1'b0, ref_strobes(i, z, c, t));
    end
    if (op == 15) begin
      for (int k = 0; k < 3; k++) begin
        ir = 8'($urandom);
        cycle("random halted", 3'd2, 1'b1, 15'h0);
      end
      rst = 1'b1;
      cycle("random halt reset", 3'd2, 1'b1, 15'h0);
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ir  = 8'h00;
    zf  = 1'b0;
    cf  = 1'b0;
    init_model();

    // Reset state.
    @(posedge clk);
    #1;
    cycle("reset", 3'd0, 1'b0, 15'h0);
    rst = 1'b0;

    // Per-cycle vector table, one instruction after another.
    add_instr(8'h00, 0, 0, 3, 15'h0, 15'h0, 15'h0);
    add_instr(8'h2A, 0, 0, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD, ALU_OUT | A_LOAD | FLAGS_LOAD);
    add_instr(8'h3B, 1, 1, 5, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
              ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB);
    add_instr(8'h1C, 0, 0, 4, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, 15'h0);
    add_instr(8'h4D, 0, 0, 4, IR_OUT | MAR_LOAD, A_OUT | RAM_LOAD, 15'h0);
    add_instr(8'h57, 0, 0, 3, IR_OUT | A_LOAD, 15'h0, 15'h0);
    add_instr(8'h62, 0, 0, 3, IR_OUT | PC_LOAD, 15'h0, 15'h0);
    add_instr(8'h73, 0, 1, 3, JUMP_TAKEN, 15'h0, 15'h0);
    add_instr(8'h73, 1, 0, 3, 15'h0, 15'h0, 15'h0);
    add_instr(8'h84, 1, 0, 3, JUMP_TAKEN, 15'h0, 15'h0);
    add_instr(8'h84, 0, 1, 3, 15'h0, 15'h0, 15'h0);
    add_instr(8'hE0, 0, 0, 3, A_OUT | OUT_LOAD, 15'h0, 15'h0);
    add_instr(8'hB5, 1, 1, 3, 15'h0, 15'h0, 15'h0);
    foreach (vecs[k]) begin
      ir = vecs[k].ir;
      zf = vecs[k].zf;
      cf = vecs[k].cf;
      cycle($sformatf("vec%0d ir=%02h", k, vecs[k].ir), vecs[k].step, 1'b0, vecs[k].strobes);
    end

    // HLT: freeze for 20 cycles, then reset clears the halt.
    ir = 8'hF0;
    cycle("hlt t0", 3'd0, 1'b0, FETCH0);
    cycle("hlt t1", 3'd1, 1'b0, FETCH1);
    cycle("hlt t2", 3'd2, 1'b0, 15'h0);
    for (int k = 0; k < 20; k++) begin
      ir = 8'($urandom);
      zf = 1'($urandom);
      cf = 1'($urandom);
      cycle("halted", 3'd2, 1'b1, 15'h0);
    end
    rst = 1'b1;
    cycle("halt reset cycle", 3'd2, 1'b1, 15'h0);
    rst = 1'b0;
    ir  = 8'h00;
    cycle("after halt reset", 3'd0, 1'b0, FETCH0);
    cycle("after halt t1", 3'd1, 1'b0, FETCH1);
    cycle("after halt t2", 3'd2, 1'b0, 15'h0);

    // Reset in T3 of STA: no ram_load, restart at T0.
    ir = 8'h45;
    cycle("sta t0", 3'd0, 1'b0, FETCH0);
    cycle("sta t1", 3'd1, 1'b0, FETCH1);
    cycle("sta t2", 3'd2, 1'b0, IR_OUT | MAR_LOAD);
    rst = 1'b1;
    cycle("sta reset in t3", 3'd3, 1'b0, 15'h0);
    rst = 1'b0;
    run_ref(8'h45, 1'b0, 1'b0);

    // Randomized instruction stream against the reference model.
    while (n_cycles < 10000)
      run_ref(8'($urandom), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
